// File: rtl/timer_reg_master_if.sv
// rtl/timer_reg_master_if.sv - command, response and timer register bus signals
interface timer_reg_master_if #(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_kind;
    logic [P_ADDR_WIDTH-1:0] cmd_addr;
    logic [P_DATA_WIDTH-1:0] cmd_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_kind;
    logic [P_DATA_WIDTH-1:0] rsp_rdata;
    logic                    rsp_err;
    logic                    bus_req;
    logic                    bus_we;
    logic [P_ADDR_WIDTH-1:0] bus_addr;
    logic [P_DATA_WIDTH-1:0] bus_wdata;
    logic                    bus_ready;
    logic [P_DATA_WIDTH-1:0] bus_rdata;

    // Initiator side: the timer_reg_master itself.
    modport master (
        input  cmd_valid, cmd_kind, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_kind, rsp_rdata, rsp_err,
        input  rsp_ready,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ready, bus_rdata
    );

    // Environment side: command source, response sink and timer responder.
    modport slave (
        output cmd_valid, cmd_kind, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_kind, rsp_rdata, rsp_err,
        output rsp_ready,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/timer_reg_master.sv
// rtl/timer_reg_master.sv - queued register-bus initiator for the timer peripheral
module timer_reg_master #(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_FIFO_DEPTH = 4,
    parameter int P_TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    timer_reg_master_if.master   bif
);
    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(P_TIMEOUT) + 1;
    localparam int EW = 1 + P_ADDR_WIDTH + P_DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           to_q, to_d;
    logic [EW-1:0]           fifo_mem_q [P_FIFO_DEPTH];
    logic [EW-1:0]           fifo_mem_d [P_FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    bus_req_q, bus_req_d;
    logic                    bus_we_q, bus_we_d;
    logic [P_ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [P_DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_kind_q, rsp_kind_d;
    logic [P_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    push, pop, timeout_hit, head_legal;
    logic [EW-1:0]           head;
    logic                    head_kind;
    logic [P_ADDR_WIDTH-1:0] head_addr;
    logic [P_DATA_WIDTH-1:0] head_wdata;

    function automatic logic is_legal(input logic [P_ADDR_WIDTH-1:0] a);
        return (a == P_ADDR_WIDTH'(0)) || (a == P_ADDR_WIDTH'(4)) || (a == P_ADDR_WIDTH'(8));
    endfunction

    assign push        = bif.cmd_valid & cmd_ready_q;
    assign pop         = (state_q == S_IDLE) && (count_q != '0);
    assign head        = fifo_mem_q[rd_ptr_q];
    assign head_kind   = head[EW-1];
    assign head_addr   = head[EW-2 -: P_ADDR_WIDTH];
    assign head_wdata  = head[P_DATA_WIDTH-1:0];
    assign head_legal  = is_legal(head_addr);
    assign timeout_hit = (to_q == TW'(P_TIMEOUT - 1));

    // Command FIFO bookkeeping; cmd_ready is registered from the post-edge fill level.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {bif.cmd_kind, bif.cmd_addr, bif.cmd_wdata};
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        cmd_ready_d = (count_d != CW'(P_FIFO_DEPTH));
    end

    // FIFO storage and pointers; reset flushes by clearing the pointers.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // FSM state register together with the access timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic; bus_ready wins over the timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    to_d    = '0;
                    state_d = head_legal ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                if (bif.bus_ready || timeout_hit) begin
                    state_d = S_RESP;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_RESP: begin
                if (bif.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered bus and response outputs.
    always_comb begin
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_kind_d  = rsp_kind_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    rsp_kind_d = head_kind;
                    if (head_legal) begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = ~head_kind;
                        bus_addr_d  = head_addr;
                        bus_wdata_d = head_wdata;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (bif.bus_ready) begin
                    bus_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus_we_q ? '0 : bif.bus_rdata;
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    bus_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            S_RESP: begin
                if (bif.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs with their reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_kind_q  <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_kind_q  <= rsp_kind_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bif.cmd_ready = cmd_ready_q;
    assign bif.bus_req   = bus_req_q;
    assign bif.bus_we    = bus_we_q;
    assign bif.bus_addr  = bus_addr_q;
    assign bif.bus_wdata = bus_wdata_q;
    assign bif.rsp_valid = rsp_valid_q;
    assign bif.rsp_kind  = rsp_kind_q;
    assign bif.rsp_rdata = rsp_rdata_q;
    assign bif.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_timer_reg_master.sv
// tb/tb_timer_reg_master.sv - self-checking bench for timer_reg_master
module tb_timer_reg_master;
    localparam int TMO = 16;

    typedef struct { logic kind; logic [7:0] addr; logic [31:0] wdata; int lat; } cmd_t;
    typedef struct { logic kind; logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { logic we; logic [7:0] addr; logic [31:0] wdata; } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timer_reg_master_if #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(32)) bif ();

    timer_reg_master #(
        .P_ADDR_WIDTH(8), .P_DATA_WIDTH(32), .P_FIFO_DEPTH(4), .P_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bif(bif)
    );

    int   n_vec = 0;
    int   n_err = 0;
    rsp_t exp_q[$];
    acc_t exp_bus_q[$];
    int   lat_q[$];
    logic [31:0] model_regs [3];
    logic [31:0] timer_regs [3];
    bit   rand_rdy = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec-level outcome of one accepted command, in command order.
    task automatic model_accept(input cmd_t c);
        rsp_t r;
        acc_t a;
        r.kind = c.kind;
        if (!(c.addr inside {8'h00, 8'h04, 8'h08})) begin
            r.rdata = '0; r.err = 1'b1;
        end else begin
            a.we = ~c.kind; a.addr = c.addr; a.wdata = c.wdata;
            exp_bus_q.push_back(a);
            lat_q.push_back(c.lat);
            if (c.lat > TMO) begin
                r.rdata = '0; r.err = 1'b1;
            end else if (c.kind == 1'b0) begin
                model_regs[c.addr[3:2]] = c.wdata;
                r.rdata = '0; r.err = 1'b0;
            end else begin
                r.rdata = model_regs[c.addr[3:2]]; r.err = 1'b0;
            end
        end
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_rdy) bif.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input cmd_t c);
        bif.cmd_valid = 1'b1;
        bif.cmd_kind  = c.kind;
        bif.cmd_addr  = c.addr;
        bif.cmd_wdata = c.wdata;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_cmd(input logic kind, input logic [7:0] addr, input logic [31:0] wdata, input int lat);
        cmd_t c;
        bit   ok = 0;
        c.kind = kind; c.addr = addr; c.wdata = wdata; c.lat = lat;
        drive(c);
        for (int i = 0; i < 300 && !ok; i++) begin
            if (bif.cmd_ready) begin
                model_accept(c);
                ok = 1;
            end
            tick();
        end
        bif.cmd_valid = 1'b0;
        chk("push_accept", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (exp_q.size() == 0 && !bif.rsp_valid && !bif.bus_req) done = 1;
            else tick();
        end
        chk("drain", 64'(done), 64'd1);
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        logic [31:0] r;
        c.kind = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0: c.addr = 8'h00;
            1: c.addr = 8'h04;
            2: c.addr = 8'h08;
            3: c.addr = 8'h0C;
            default: begin r = $urandom; c.addr = r[7:0]; end
        endcase
        c.wdata = $urandom;
        c.lat   = ($urandom_range(0, 9) < 2) ? int'($urandom_range(TMO - 2, TMO + 3))
                                             : int'($urandom_range(1, 4));
        return c;
    endfunction

    // Timer responder: completes each access after its scheduled latency.
    initial begin
        int   cnt = 0;
        int   cur_lat = 0;
        bit   active = 0;
        acc_t a;
        bif.bus_ready = 1'b0;
        bif.bus_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                active = 0; bif.bus_ready = 1'b0;
                lat_q.delete(); exp_bus_q.delete();
            end else if (bif.bus_req) begin
                if (!active) begin
                    active = 1; cnt = 0;
                    chk("bus_access_expected", 64'(exp_bus_q.size() != 0), 64'd1);
                    if (exp_bus_q.size() != 0) begin
                        a = exp_bus_q.pop_front();
                        chk("bus_we", 64'(bif.bus_we), 64'(a.we));
                        chk("bus_addr", 64'(bif.bus_addr), 64'(a.addr));
                        if (a.we) chk("bus_wdata", 64'(bif.bus_wdata), 64'(a.wdata));
                    end
                    cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 1000;
                end
                cnt++;
                if (cnt == cur_lat) begin
                    bif.bus_ready = 1'b1;
                    if (bif.bus_we) timer_regs[bif.bus_addr[3:2]] = bif.bus_wdata;
                    bif.bus_rdata = bif.bus_we ? $urandom : timer_regs[bif.bus_addr[3:2]];
                end else begin
                    bif.bus_ready = 1'b0;
                    bif.bus_rdata = $urandom;
                end
            end else begin
                active = 0; bif.bus_ready = 1'b0; bif.bus_rdata = $urandom;
            end
        end
    end

    // Response monitor: in-order scoreboard plus hold-while-stalled check.
    initial begin
        bit   hold = 0;
        rsp_t held;
        rsp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_q.delete(); hold = 0;
            end else begin
                if (hold) begin
                    chk("rsp_valid_held", 64'(bif.rsp_valid), 64'd1);
                    chk("rsp_held_stable", {bif.rsp_kind, bif.rsp_err, bif.rsp_rdata},
                        {held.kind, held.err, held.rdata});
                end
                if (bif.rsp_valid && bif.rsp_ready) begin
                    chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rsp_kind", 64'(bif.rsp_kind), 64'(e.kind));
                        chk("rsp_rdata", 64'(bif.rsp_rdata), 64'(e.rdata));
                        chk("rsp_err", 64'(bif.rsp_err), 64'(e.err));
                    end
                    hold = 0;
                end else if (bif.rsp_valid) begin
                    hold = 1;
                    held.kind = bif.rsp_kind; held.rdata = bif.rsp_rdata; held.err = bif.rsp_err;
                end else begin
                    hold = 0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c6 [6];
        int   idx;
        int   n;
        bit   ok;
        bif.cmd_valid = 1'b0; bif.cmd_kind = 1'b0; bif.cmd_addr = '0; bif.cmd_wdata = '0;
        bif.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_regs[i] = $urandom;
            timer_regs[i] = model_regs[i];
        end

        // Reset values.
        tick(); tick();
        chk("rst_bus_req", 64'(bif.bus_req), 64'd0);
        chk("rst_bus_we", 64'(bif.bus_we), 64'd0);
        chk("rst_bus_addr", 64'(bif.bus_addr), 64'd0);
        chk("rst_bus_wdata", 64'(bif.bus_wdata), 64'd0);
        chk("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
        chk("rst_rsp_kind", 64'(bif.rsp_kind), 64'd0);
        chk("rst_rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(bif.rsp_err), 64'd0);
        chk("rst_cmd_ready", 64'(bif.cmd_ready), 64'd1);
        rst = 1'b0;
        tick();

        // Single WRITE then READ, with pop/issue latency.
        push_cmd(1'b0, 8'h04, 32'h0000_1234, 2);
        chk("pre_pop_bus_req", 64'(bif.bus_req), 64'd0);
        tick();
        chk("issue_bus_req", 64'(bif.bus_req), 64'd1);
        chk("issue_bus_we_w", 64'(bif.bus_we), 64'd1);
        drain();
        push_cmd(1'b1, 8'h04, 32'h0, 1);
        tick();
        chk("issue_bus_we_r", 64'(bif.bus_we), 64'd0);
        drain();

        // Illegal address: response one cycle after the pop, no bus activity.
        push_cmd(1'b1, 8'h0C, 32'h0, 1);
        chk("illegal_pre_pop", 64'(bif.rsp_valid), 64'd0);
        tick();
        chk("illegal_rsp_valid", 64'(bif.rsp_valid), 64'd1);
        chk("illegal_rsp_err", 64'(bif.rsp_err), 64'd1);
        chk("illegal_no_bus_req", 64'(bif.bus_req), 64'd0);
        drain();

        // Timeout: bus_req high exactly TMO cycles, then recovery.
        push_cmd(1'b1, 8'h08, 32'h0, 1000);
        tick();
        n = 0;
        while (bif.bus_req && n < 100) begin
            n++;
            tick();
        end
        chk("timeout_req_cycles", 64'(n), 64'(TMO));
        chk("timeout_rsp_valid", 64'(bif.rsp_valid), 64'd1);
        chk("timeout_rsp_err", 64'(bif.rsp_err), 64'd1);
        drain();
        push_cmd(1'b0, 8'h00, $urandom, 3);
        drain();

        // Priority boundary: ready on the last allowed cycle, then one cycle late.
        push_cmd(1'b1, 8'h08, 32'h0, TMO);
        push_cmd(1'b0, 8'h08, $urandom, TMO);
        push_cmd(1'b1, 8'h08, 32'h0, TMO + 1);
        push_cmd(1'b1, 8'h08, 32'h0, 1);
        drain();

        // FIFO full under response backpressure.
        bif.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) c6[i] = rand_cmd();
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(c6[idx]);
            if (bif.cmd_ready) begin
                model_accept(c6[idx]);
                idx++;
            end
            tick();
        end
        chk("full_accepted", 64'(idx), 64'd5);
        chk("full_cmd_ready", 64'(bif.cmd_ready), 64'd0);
        tick(); tick(); tick();
        chk("full_cmd_ready_hold", 64'(bif.cmd_ready), 64'd0);
        bif.rsp_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 300 && !ok && idx < 6; i++) begin
            drive(c6[idx]);
            if (bif.cmd_ready) begin
                model_accept(c6[idx]);
                ok = 1;
            end
            tick();
        end
        bif.cmd_valid = 1'b0;
        chk("full_last_accept", 64'(ok), 64'd1);
        drain();

        // Randomized traffic with random response backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            cmd_t c;
            c = rand_cmd();
            push_cmd(c.kind, c.addr, c.wdata, c.lat);
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) tick();
        end
        drain();
        rand_rdy = 0;
        bif.rsp_ready = 1'b1;
        tick();

        // Reset during an access with three commands queued.
        push_cmd(1'b1, 8'h00, 32'h0, 1000);
        push_cmd(1'b0, 8'h04, $urandom, 1000);
        push_cmd(1'b1, 8'h08, 32'h0, 1000);
        push_cmd(1'b0, 8'h00, $urandom, 1000);
        chk("mid_bus_req", 64'(bif.bus_req), 64'd1);
        rst = 1'b1;
        tick();
        chk("midrst_bus_req", 64'(bif.bus_req), 64'd0);
        chk("midrst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
        chk("midrst_cmd_ready", 64'(bif.cmd_ready), 64'd1);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("midrst_no_bus_req", 64'(bif.bus_req), 64'd0);
        chk("midrst_no_rsp", 64'(bif.rsp_valid), 64'd0);
        push_cmd(1'b0, 8'h04, 32'hCAFE_0001, 2);
        push_cmd(1'b1, 8'h04, 32'h0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/timer_reg_master.md
# timer_reg_master

Register-bus initiator that drives the timer peripheral's register interface. It accepts WRITE/READ commands from a valid/ready upstream port and buffers them in a small FIFO. It issues them one at a time on the timer register bus, with a req/ready handshake and a timeout, and returns one response per command. The block sits between the test/firmware command source and the timer. It is the initiator counterpart of the timer's register responder.

## Interface
Parameters:
- P_ADDR_WIDTH, 8, register address width
- P_DATA_WIDTH, 32, register data width
- P_FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- P_TIMEOUT, 16, max cycles bus_req may wait for bus_ready (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_kind  in  1  0=WRITE, 1=READ
- cmd_addr  in  P_ADDR_WIDTH  register address
- cmd_wdata  in  P_DATA_WIDTH  write data (ignored for READ)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_kind  out  1  kind of completed command
- rsp_rdata  out  P_DATA_WIDTH  read data; 0 for WRITE or error
- rsp_err  out  1  illegal address or timeout
- bus_req  out  1  access request to timer
- bus_we  out  1  1=write, 0=read
- bus_addr  out  P_ADDR_WIDTH  access address
- bus_wdata  out  P_DATA_WIDTH  write data
- bus_ready  in  1  timer completes access this cycle
- bus_rdata  in  P_DATA_WIDTH  read data, valid with bus_ready on reads

## Operation
- FIFO push: on cmd_valid & cmd_ready. cmd_ready = !full.
  - No same-cycle bypass: when full, cmd_ready stays 0 even if a pop occurs that cycle.
- Legal addresses: 0x00 CONTROL, 0x04 LOAD, 0x08 STATUS. Any other address is illegal.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if FIFO non-empty, pop the head into the command register.
    - Legal address: go to ACCESS.
    - Illegal address: go to RESP with err=1 and rdata=0. No bus activity.
  - ACCESS: bus_req=1. bus_we, bus_addr and bus_wdata are stable from the command register.
    - Timeout counter clears on entry and increments each ACCESS cycle.
    - On bus_ready=1 at a rising edge: capture bus_rdata (reads) or 0 (writes), err=0, go to RESP.
    - Else, if the counter reaches P_TIMEOUT−1: err=1, rdata=0, go to RESP.
    - bus_ready takes priority over timeout in the same cycle.
  - RESP: rsp_valid=1 with rsp_kind, rsp_rdata and rsp_err held stable. On rsp_ready, go to IDLE.
- Commands complete strictly in order, with at most one bus access outstanding.
- bus_ready outside ACCESS is ignored.
- Timeout counter width: $clog2(P_TIMEOUT)+1 bits; it never wraps.

## Timing
- All outputs are registered.
- Reset values:
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0
  - rsp_valid=0, rsp_kind=0, rsp_rdata=0, rsp_err=0
  - cmd_ready=1, FIFO empty, state IDLE
- Command accepted into an empty FIFO at edge N, with the FSM in IDLE:
  - pop at edge N+1;
  - bus_req=1 in the cycle after edge N+1.
- bus_ready seen at edge M: bus_req=0 and rsp_valid=1 in the cycle after M. Minimum ACCESS length is 1 cycle.
- Timeout: bus_req stays high exactly P_TIMEOUT cycles, then drops as rsp_valid rises.
- Illegal address: rsp_valid=1 in the cycle after the pop edge.
- The FSM re-enters IDLE on the edge where rsp_valid & rsp_ready. The next pop happens no earlier than the following edge, so back-to-back bus accesses are separated by at least 2 idle cycles.
- rsp_valid is never withdrawn without rsp_ready.
- rst mid-operation: at the next edge all outputs take their reset values, the FIFO is flushed, and any in-flight command and pending response are discarded.

## Test plan
- Single WRITE then READ:
  - Stimulus: WRITE 0x04 ← 0x0000_1234 with bus_ready after 2 cycles, then READ 0x04 with bus_rdata=0x0000_1234.
  - Response: two responses, WRITE (rdata=0, err=0) then READ (rdata=0x1234, err=0). bus_we=1 then 0.
- Illegal address:
  - Stimulus: READ 0x0C.
  - Response: no bus_req, and the response has err=1, rdata=0, one cycle after the pop.
- Timeout:
  - Stimulus: READ 0x08 with bus_ready held 0.
  - Response: bus_req high exactly 16 cycles, then a response with err=1, rdata=0. The next command proceeds normally.
- FIFO full and backpressure:
  - Stimulus: rsp_ready=0 with 6 commands pushed back-to-back.
  - Response: 1 command in RESP and 4 in the FIFO, with cmd_ready=0 from that point. After rsp_ready=1, all commands complete in order with correct kinds and addresses.
- Boundary priority: bus_ready asserted on the same cycle the timeout counter reaches 15 → err=0 and data captured.
- Reset mid-access:
  - Stimulus: assert rst during ACCESS with 3 commands queued.
  - Response: next cycle bus_req=0, rsp_valid=0, cmd_ready=1, and no response is emitted for the discarded commands.
